// File: rtl/uart_pkg.sv
// Shared types and constants for the UART echo path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    // Echo controller FSM encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        BUSY = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    // One bit time at 9600 baud from a 50 MHz clock.
    localparam int BPS      = 5208;
    localparam int BPS_HALF = BPS / 2;

endpackage

// File: rtl/uart_sync_fifo.sv
// Byte FIFO with first-word-fall-through head and occupancy count.
// Latency: push visible in cnt/dout the cycle after; pop frees the head the cycle after.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
module uart_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic [AW:0]   cnt,
    output logic          full,
    output logic          empty
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage array; contents need no reset since cnt gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH because DEPTH is 2**AW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/uart_echo_ctrl.sv
// Buffers received bytes and feeds them one at a time to the UART transmitter.
// Latency: rx_vld at t -> fifo_cnt=1 at t+1 -> tx_start at t+2 -> fifo_cnt=0 at t+3.
// Backpressure: waits on tx_busy; bytes arriving to a full FIFO with no pop are dropped (ovf).
module uart_echo_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int GAP_CYC = BPS,
    parameter int ACK_TO  = 16,
    parameter bit CRLF_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    rx_data,
    input  logic          rx_vld,
    input  logic          tx_busy,
    output logic [7:0]    tx_data,
    output logic          tx_start,
    output logic [AW:0]   fifo_cnt,
    output logic          ovf,
    output logic          ack_err,
    input  logic          clr
);

    state_t      state_q, state_d;
    logic [31:0] tmr_q, tmr_d;
    logic [7:0]  data_d;
    logic        start_d;
    logic        pop_q, pop_d;
    logic        lf_pend_q, lf_pend_d;
    logic        ack_set;
    logic        ovf_set;
    logic        fifo_push;
    logic [7:0]  fifo_dout;
    logic        fifo_full;
    logic        fifo_empty;

    // The head is copied into tx_data when the start is issued, but the
    // entry is released one cycle later, alongside the start pulse.
    assign fifo_push = rx_vld && (!fifo_full || pop_q);
    assign ovf_set   = rx_vld && fifo_full && !pop_q;

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (pop_q),
        .din   (rx_data),
        .dout  (fifo_dout),
        .cnt   (fifo_cnt),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state, shared timer and start/data scheduling.
    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        data_d    = tx_data;
        start_d   = 1'b0;
        pop_d     = 1'b0;
        lf_pend_d = lf_pend_q;
        ack_set   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && !tx_busy) begin
                    data_d    = fifo_dout;
                    start_d   = 1'b1;
                    pop_d     = 1'b1;
                    lf_pend_d = CRLF_EN && (fifo_dout == CR);
                    tmr_d     = '0;
                    state_d   = ACK;
                end
            end
            ACK: begin
                if (tx_busy) begin
                    state_d = BUSY;
                end else if (tmr_q == 32'(ACK_TO - 1)) begin
                    // Transmitter never answered: the byte is lost, and so is its LF.
                    ack_set   = 1'b1;
                    lf_pend_d = 1'b0;
                    tmr_d     = '0;
                    state_d   = GAP;
                end else begin
                    tmr_d = tmr_q + 32'd1;
                end
            end
            BUSY: begin
                if (!tx_busy) begin
                    tmr_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (tmr_q != 32'(GAP_CYC - 1)) begin
                    tmr_d = tmr_q + 32'd1;
                end else if (!tx_busy) begin
                    tmr_d = '0;
                    if (lf_pend_q) begin
                        data_d    = LF;
                        start_d   = 1'b1;
                        lf_pend_d = 1'b0;
                        state_d   = ACK;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, registered outputs and sticky flags (a set beats a clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tmr_q     <= '0;
            tx_data   <= '0;
            tx_start  <= 1'b0;
            pop_q     <= 1'b0;
            lf_pend_q <= 1'b0;
            ovf       <= 1'b0;
            ack_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            tx_data   <= data_d;
            tx_start  <= start_d;
            pop_q     <= pop_d;
            lf_pend_q <= lf_pend_d;
            ovf       <= ovf_set | (ovf & ~clr);
            ack_err   <= ack_set | (ack_err & ~clr);
        end
    end

endmodule

// File: tb/tb_uart_echo_ctrl.sv
// Self-checking bench for uart_echo_ctrl with a behavioural transmitter model.
// Latency: n/a.
// Backpressure: transmitter busy length and response are controlled per scenario.
module tb_uart_echo_ctrl;

    localparam int DEPTH  = 16;
    localparam int AW     = 4;
    localparam int GAP    = 20;
    localparam int ATO    = 16;
    localparam int QUIET  = GAP + ATO + 10;
    localparam logic [7:0] B_CR = 8'h0D;
    localparam logic [7:0] B_LF = 8'h0A;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    rx_data = '0;
    logic          rx_vld = 1'b0;
    logic          tx_busy;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic [AW:0]   fifo_cnt;
    logic          ovf;
    logic          ack_err;
    logic          clr = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Transmitter model controls.
    logic force_busy = 1'b0;
    logic respond    = 1'b1;
    int   busy_len   = 10;
    logic mbusy;
    int   rem;

    logic [7:0] q_got[$];
    int         q_t[$];

    assign tx_busy = mbusy | force_busy;

    uart_echo_ctrl #(
        .DEPTH   (DEPTH),
        .AW      (AW),
        .GAP_CYC (GAP),
        .ACK_TO  (ATO),
        .CRLF_EN (1'b1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_vld   (rx_vld),
        .tx_busy  (tx_busy),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .fifo_cnt (fifo_cnt),
        .ovf      (ovf),
        .ack_err  (ack_err),
        .clr      (clr)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter: busy for busy_len cycles starting the cycle after a start.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mbusy <= 1'b0;
            rem   <= 0;
        end else if (tx_start && respond) begin
            mbusy <= 1'b1;
            rem   <= busy_len - 1;
        end else if (rem > 0) begin
            rem <= rem - 1;
        end else begin
            mbusy <= 1'b0;
        end
    end

    // Record every start and check it never overlaps busy.
    always @(negedge clk) begin
        if (tx_start) begin
            q_got.push_back(tx_data);
            q_t.push_back(cyc);
            n_tests++;
            if (tx_busy) begin
                n_fail++;
                $display("FAIL start_while_busy: tx_start=1 with tx_busy=%0b", tx_busy);
            end
        end
    end

    // Reference: bytes leave in arrival order, each CR followed by an LF.
    function automatic void expand(input logic [7:0] src[$], output logic [7:0] dst[$]);
        dst = {};
        foreach (src[i]) begin
            dst.push_back(src[i]);
            if (src[i] == B_CR) dst.push_back(B_LF);
        end
    endfunction

    task automatic clear_log();
        q_got = {};
        q_t   = {};
    endtask

    task automatic send_burst(input logic [7:0] b[$]);
        foreach (b[i]) begin
            @(negedge clk);
            rx_data = b[i];
            rx_vld  = 1'b1;
        end
        @(negedge clk);
        rx_vld = 1'b0;
    endtask

    task automatic drain();
        int quiet = 0;
        int t = 0;
        while (quiet < QUIET && t < 30000) begin
            @(negedge clk);
            t++;
            if (tx_start || fifo_cnt != 0 || tx_busy) quiet = 0;
            else quiet++;
        end
        n_tests++;
        if (quiet < QUIET) begin
            n_fail++;
            $display("FAIL drain_timeout: quiet=%0d required=%0d", quiet, QUIET);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({tx_start, tx_data, fifo_cnt, ovf, ack_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: start=%0b data=%h cnt=%0d ovf=%0b ack=%0b required all 0",
                     tx_start, tx_data, fifo_cnt, ovf, ack_err);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        busy_len = 10;
        clear_log();
        @(negedge clk);
        rx_data = 8'h41;
        rx_vld  = 1'b1;
        @(negedge clk);
        rx_vld = 1'b0;
        n_tests++;
        if (fifo_cnt !== 1 || tx_start !== 1'b0) begin
            n_fail++;
            $display("FAIL single_t1: cnt=%0d start=%0b required cnt=1 start=0", fifo_cnt, tx_start);
        end
        @(negedge clk);
        n_tests++;
        if (tx_start !== 1'b1 || tx_data !== 8'h41) begin
            n_fail++;
            $display("FAIL single_t2: start=%0b data=%h required start=1 data=41", tx_start, tx_data);
        end
        @(negedge clk);
        n_tests++;
        if (fifo_cnt !== 0 || tx_start !== 1'b0) begin
            n_fail++;
            $display("FAIL single_t3: cnt=%0d start=%0b required cnt=0 start=0", fifo_cnt, tx_start);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [7:0] src[$];
        logic [7:0] exp[$];
        busy_len = 10;
        clear_log();
        src = {8'h41, 8'h42, 8'h43};
        send_burst(src);
        drain();
        expand(src, exp);
        n_tests++;
        if (q_got.size() != exp.size()) begin
            n_fail++;
            $display("FAIL b2b_count: got=%0d required=%0d", q_got.size(), exp.size());
        end else begin
            foreach (exp[i]) begin
                n_tests++;
                if (q_got[i] !== exp[i]) begin
                    n_fail++;
                    $display("FAIL b2b_byte[%0d]: got=%h required=%h", i, q_got[i], exp[i]);
                end
            end
            for (int i = 1; i < q_t.size(); i++) begin
                n_tests++;
                if (q_t[i] - q_t[i-1] < busy_len + GAP) begin
                    n_fail++;
                    $display("FAIL b2b_gap[%0d]: spacing=%0d required>=%0d", i, q_t[i] - q_t[i-1], busy_len + GAP);
                end
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] src[$];
        logic [7:0] exp[$];
        clear_log();
        force_busy = 1'b1;
        busy_len   = 3;
        src = {};
        for (int i = 0; i < 17; i++) src.push_back(8'(i));
        send_burst(src);
        n_tests++;
        if (fifo_cnt !== 5'(DEPTH) || ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_full: cnt=%0d ovf=%0b required cnt=16 ovf=1", fifo_cnt, ovf);
        end
        force_busy = 1'b0;
        drain();
        void'(src.pop_back());
        expand(src, exp);
        n_tests++;
        if (q_got.size() != exp.size()) begin
            n_fail++;
            $display("FAIL ovf_count: got=%0d required=%0d", q_got.size(), exp.size());
        end else begin
            foreach (exp[i]) begin
                n_tests++;
                if (q_got[i] !== exp[i]) begin
                    n_fail++;
                    $display("FAIL ovf_byte[%0d]: got=%h required=%h", i, q_got[i], exp[i]);
                end
            end
        end
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        n_tests++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clr: ovf=%0b required 0", ovf);
        end
    endtask

    task automatic test_full_pop();
        logic [7:0] src[$];
        logic [7:0] exp[$];
        int t = 0;
        clear_log();
        busy_len   = 2;
        force_busy = 1'b1;
        src = {};
        for (int i = 0; i < DEPTH; i++) src.push_back(8'($urandom_range(8'h20, 8'h7E)));
        send_burst(src);
        force_busy = 1'b0;
        while (!tx_start && t < 50) begin
            @(negedge clk);
            t++;
        end
        rx_data = 8'hEE;
        rx_vld  = 1'b1;
        @(negedge clk);
        rx_vld = 1'b0;
        n_tests++;
        if (t >= 50 || fifo_cnt !== 5'(DEPTH) || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL full_pop: wait=%0d cnt=%0d ovf=%0b required cnt=16 ovf=0", t, fifo_cnt, ovf);
        end
        drain();
        src.push_back(8'hEE);
        expand(src, exp);
        n_tests++;
        if (q_got != exp) begin
            n_fail++;
            $display("FAIL full_pop_seq: got %0d bytes (first %h) required %0d bytes (first %h)",
                     q_got.size(), q_got[0], exp.size(), exp[0]);
        end
    endtask

    task automatic test_crlf();
        logic [7:0] exp[$];
        int maxc = 0;
        clear_log();
        busy_len = 4;
        @(negedge clk);
        rx_data = B_CR;
        rx_vld  = 1'b1;
        @(negedge clk);
        rx_data = 8'h42;
        @(negedge clk);
        rx_vld = 1'b0;
        for (int i = 0; i < 4 * (GAP + busy_len) + 20; i++) begin
            @(negedge clk);
            if (int'(fifo_cnt) > maxc) maxc = int'(fifo_cnt);
        end
        drain();
        exp = {B_CR, B_LF, 8'h42};
        n_tests++;
        if (q_got != exp) begin
            n_fail++;
            $display("FAIL crlf_seq: got %0d bytes required 0D 0A 42", q_got.size());
        end
        n_tests++;
        if (maxc > 1) begin
            n_fail++;
            $display("FAIL crlf_cnt: max fifo_cnt after load=%0d required<=1", maxc);
        end
    endtask

    task automatic test_ack_timeout();
        logic [7:0] exp[$];
        int e;
        int t;
        clear_log();
        busy_len = 5;
        respond  = 1'b0;
        exp = {B_CR};
        send_burst(exp);
        t = 0;
        while (!tx_start && t < 20) begin
            @(negedge clk);
            t++;
        end
        e = 0;
        while (e < ATO - 1) begin
            @(negedge clk);
            e++;
            n_tests++;
            if (ack_err !== 1'b0) begin
                n_fail++;
                $display("FAIL ack_early: ack_err=1 after %0d cycles required 0", e);
            end
        end
        @(negedge clk);
        n_tests++;
        if (ack_err !== 1'b1) begin
            n_fail++;
            $display("FAIL ack_timeout: ack_err=%0b after %0d cycles required 1", ack_err, ATO);
        end
        respond = 1'b1;
        exp = {8'h61};
        send_burst(exp);
        drain();
        exp = {B_CR, 8'h61};
        n_tests++;
        if (q_got != exp) begin
            n_fail++;
            $display("FAIL ack_seq: got %0d bytes required 0D 61 (no LF)", q_got.size());
        end
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        n_tests++;
        if (ack_err !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_clr: ack_err=%0b required 0", ack_err);
        end
        // clr in the same cycle as a fresh timeout
        respond = 1'b0;
        exp = {8'h33};
        send_burst(exp);
        t = 0;
        while (!tx_start && t < 20) begin
            @(negedge clk);
            t++;
        end
        repeat (ATO - 1) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        n_tests++;
        if (ack_err !== 1'b1) begin
            n_fail++;
            $display("FAIL ack_set_wins: ack_err=%0b required 1", ack_err);
        end
        respond = 1'b1;
        drain();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] src[$];
        logic [7:0] exp[$];
        int n;
        for (int r = 0; r < 4; r++) begin
            clear_log();
            busy_len = $urandom_range(1, 15);
            n = $urandom_range(1, 12);
            src = {};
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) src.push_back(B_CR);
                else src.push_back(8'($urandom));
            end
            foreach (src[i]) begin
                @(negedge clk);
                rx_data = src[i];
                rx_vld  = 1'b1;
                @(negedge clk);
                rx_vld = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            drain();
            expand(src, exp);
            n_tests++;
            if (q_got != exp || ovf !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_seq[%0d]: got %0d bytes ovf=%0b required %0d bytes ovf=0",
                         r, q_got.size(), ovf, exp.size());
            end
            for (int i = 1; i < q_t.size(); i++) begin
                n_tests++;
                if (q_t[i] - q_t[i-1] < busy_len + GAP) begin
                    n_fail++;
                    $display("FAIL rand_gap[%0d]: spacing=%0d required>=%0d", i, q_t[i] - q_t[i-1], busy_len + GAP);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] src[$];
        int t = 0;
        busy_len = 50;
        src = {8'h11, 8'h22, 8'h33, 8'h44};
        send_burst(src);
        while (!(tx_busy && fifo_cnt == 3) && t < 50) begin
            @(negedge clk);
            t++;
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (t >= 50 || {tx_start, tx_data, fifo_cnt, ovf, ack_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: wait=%0d start=%0b data=%h cnt=%0d ovf=%0b ack=%0b required all 0",
                     t, tx_start, tx_data, fifo_cnt, ovf, ack_err);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_log();
        repeat (200) @(negedge clk);
        n_tests++;
        if (q_got.size() != 0 || fifo_cnt !== 0) begin
            n_fail++;
            $display("FAIL reset_quiet: starts=%0d cnt=%0d required 0 0", q_got.size(), fifo_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_crlf();
        test_overflow();
        test_full_pop();
        test_ack_timeout();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
